// File: rtl/ace_desc_req_arbiter_pkg.sv
// Shared types and helpers for the descriptor request arbiter.
// FSM encoding is fixed so debug taps and checkers can decode it directly.
package ace_desc_req_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE = 2'd0,
      ARB_WAIT = 2'd1,
      ARB_GAP  = 2'd2
   } arb_state_e;

   // Index width that never collapses to zero bits for tiny counts.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/ace_desc_req_arbiter_if.sv
// Requester/allocator bundle of the descriptor request arbiter.
// slave = arbiter side, master = requesters plus allocator side.
interface ace_desc_req_arbiter_if
   import ace_desc_req_arbiter_pkg::*;
#(
   parameter int NUM_REQ = 3,
   parameter int DW      = 3
);

   // Handshakes: req is a level held until its gnt bit pulses for one cycle
   // (gnt_desc_idx valid only while |gnt); rel is a one-cycle pulse returning
   // one descriptor; txn_valid asks the allocator for one descriptor on its
   // rising edge and stays high until desc_alc_valid pulses for one cycle
   // carrying desc_alc_idx.
   logic [NUM_REQ-1:0] req;
   logic [NUM_REQ-1:0] gnt;
   logic [DW-1:0]      gnt_desc_idx;
   logic [NUM_REQ-1:0] rel;
   logic               txn_valid;
   logic               desc_alc_valid;
   logic [DW-1:0]      desc_alc_idx;
   logic               busy;
   logic               err_underflow;
   arb_state_e         dbg_state;

   modport slave (
      input  req,
      input  rel,
      input  desc_alc_valid,
      input  desc_alc_idx,
      output gnt,
      output gnt_desc_idx,
      output txn_valid,
      output busy,
      output err_underflow,
      output dbg_state
   );

   modport master (
      output req,
      output rel,
      output desc_alc_valid,
      output desc_alc_idx,
      input  gnt,
      input  gnt_desc_idx,
      input  txn_valid,
      input  busy,
      input  err_underflow,
      input  dbg_state
   );

endinterface

// File: rtl/ace_desc_req_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first eligible requester after ptr_i,
// wrapping, with ptr_i itself checked last.
module rr_arbiter #(
   parameter int N  = 3,
   parameter int PW = 2
) (
   input  logic [N-1:0]  elig_i,
   input  logic [PW-1:0] ptr_i,
   output logic          any_o,
   output logic [PW-1:0] win_idx_o
);

   logic [PW-1:0] idx;

   // Walk from the farthest candidate to the nearest so the nearest hit wins.
   always_comb begin
      any_o     = 1'b0;
      win_idx_o = '0;
      idx       = '0;
      for (int k = N; k >= 1; k--) begin
         idx = PW'((int'(ptr_i) + k) % N);
         if (elig_i[idx]) begin
            any_o     = 1'b1;
            win_idx_o = idx;
         end
      end
   end

endmodule

// File: rtl/ace_desc_req_arbiter.sv
// Shares one descriptor allocator between NUM_REQ requesters: round-robin pick,
// edge-triggered allocator request, one-cycle grant, per-requester quota.
module ace_desc_req_arbiter
   import ace_desc_req_arbiter_pkg::*;
#(
   parameter int NUM_REQ  = 3,
   parameter int MAX_DESC = 8,
   parameter int QUOTA    = 4
) (
   input  logic                  clk,
   input  logic                  resetn,
   ace_desc_req_arbiter_if.slave arb_io
);

   localparam int DW = clog2_min1(MAX_DESC);
   localparam int PW = clog2_min1(NUM_REQ);
   localparam int CW = clog2_min1(QUOTA + 1);

   arb_state_e         state_q, state_d;
   logic [PW-1:0]      win_q, win_d;
   logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
   logic [NUM_REQ-1:0] gnt_q, gnt_d;
   logic [DW-1:0]      gnt_idx_q, gnt_idx_d;
   logic               txn_valid_q, txn_valid_d;
   logic               busy_q, busy_d;
   logic               err_q, err_d;

   logic [NUM_REQ-1:0] elig;
   logic [NUM_REQ-1:0] rel_under;
   logic               any_elig;
   logic [PW-1:0]      rr_win;
   logic               grant_fire;

   assign grant_fire = (state_q == ARB_WAIT) && arb_io.desc_alc_valid;

   // Per-requester outstanding-descriptor counters; a grant and a release in
   // the same cycle cancel out.
   for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
      logic [CW-1:0] cnt_q;
      logic          inc;
      logic          dec;

      assign inc          = grant_fire && (win_q == PW'(i));
      assign dec          = arb_io.rel[i] && (cnt_q != '0);
      assign elig[i]      = arb_io.req[i] && (cnt_q < CW'(QUOTA));
      assign rel_under[i] = arb_io.rel[i] && (cnt_q == '0);

      always_ff @(posedge clk) begin
         if (!resetn) begin
            cnt_q <= '0;
         end else if (inc && !arb_io.rel[i]) begin
            cnt_q <= cnt_q + CW'(1);
         end else if (dec && !inc) begin
            cnt_q <= cnt_q - CW'(1);
         end
      end
   end

   rr_arbiter #(
      .N  (NUM_REQ),
      .PW (PW)
   ) u_rr (
      .elig_i    (elig),
      .ptr_i     (rr_ptr_q),
      .any_o     (any_elig),
      .win_idx_o (rr_win)
   );

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q <= ARB_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ARB_IDLE: if (any_elig) state_d = ARB_WAIT;
         ARB_WAIT: if (arb_io.desc_alc_valid) state_d = ARB_GAP;
         ARB_GAP:  state_d = ARB_IDLE;
         default:  state_d = ARB_IDLE;
      endcase
   end

   // txn_valid is low in GAP so the allocator always sees a fresh rising edge.
   always_comb begin
      win_d       = win_q;
      rr_ptr_d    = rr_ptr_q;
      gnt_d       = '0;
      gnt_idx_d   = gnt_idx_q;
      txn_valid_d = 1'b0;
      case (state_q)
         ARB_IDLE: begin
            if (any_elig) begin
               win_d       = rr_win;
               txn_valid_d = 1'b1;
            end
         end
         ARB_WAIT: begin
            if (arb_io.desc_alc_valid) begin
               gnt_d[win_q] = 1'b1;
               gnt_idx_d    = arb_io.desc_alc_idx;
               rr_ptr_d     = win_q;
            end else begin
               txn_valid_d = 1'b1;
            end
         end
         default: ;
      endcase
      busy_d = (state_d != ARB_IDLE);
      err_d  = err_q | (|rel_under);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         win_q       <= '0;
         rr_ptr_q    <= PW'(NUM_REQ - 1);
         gnt_q       <= '0;
         gnt_idx_q   <= '0;
         txn_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         win_q       <= win_d;
         rr_ptr_q    <= rr_ptr_d;
         gnt_q       <= gnt_d;
         gnt_idx_q   <= gnt_idx_d;
         txn_valid_q <= txn_valid_d;
         busy_q      <= busy_d;
         err_q       <= err_d;
      end
   end

   assign arb_io.gnt           = gnt_q;
   assign arb_io.gnt_desc_idx  = gnt_idx_q;
   assign arb_io.txn_valid     = txn_valid_q;
   assign arb_io.busy          = busy_q;
   assign arb_io.err_underflow = err_q;
   assign arb_io.dbg_state     = state_q;

   // An allocation outside WAIT has no owner and is dropped.
   alc_only_in_wait: assert property (@(posedge clk) disable iff (!resetn)
      arb_io.desc_alc_valid |-> (state_q == ARB_WAIT));

endmodule

// File: tb/tb_ace_desc_req_arbiter.sv
// Self-checking bench for ace_desc_req_arbiter with a delayed-response
// allocator model and a grant-order reference model.
module tb_ace_desc_req_arbiter;
   import ace_desc_req_arbiter_pkg::*;

   localparam int NREQ  = 3;
   localparam int QUOTA = 2;
   localparam int DW    = 3;

   // ---------------- clock / reset ----------------
   logic clk    = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   ace_desc_req_arbiter_if #(.NUM_REQ(NREQ), .DW(DW)) bus ();

   ace_desc_req_arbiter #(
      .NUM_REQ  (NREQ),
      .MAX_DESC (8),
      .QUOTA    (QUOTA)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .arb_io (bus)
   );

   int n_vec = 0;
   int n_err = 0;

   // ---------------- reference model ----------------
   int m_cnt[NREQ];
   int m_ptr;
   bit m_under;

   // Requesters are scanned in order after the last winner; quota-full ones skip.
   function automatic int model_pick(input logic [NREQ-1:0] r);
      for (int k = 1; k <= NREQ; k++) begin
         int i;
         i = (m_ptr + k) % NREQ;
         if (r[i] && m_cnt[i] < QUOTA) return i;
      end
      return -1;
   endfunction

   function automatic logic [NREQ-1:0] onehot(input int i);
      logic [NREQ-1:0] v;
      v = '0;
      if (i >= 0 && i < NREQ) v[i] = 1'b1;
      return v;
   endfunction

   // ---------------- allocator model ----------------
   logic [DW-1:0] exp_q[$];
   logic [DW-1:0] alc_idx_q[$];
   int alc_force_delay = 0;
   int last_alc_cyc    = 0;

   initial begin
      bit seen;
      bit pending;
      int left;
      seen = 0;
      pending = 0;
      left = 0;
      bus.desc_alc_valid = 1'b0;
      bus.desc_alc_idx   = '0;
      forever begin
         @(negedge clk);
         bus.desc_alc_valid = 1'b0;
         if (!resetn) begin
            seen = 0;
            pending = 0;
         end else begin
            if (bus.txn_valid && !seen && !pending) begin
               pending = 1;
               left = (alc_force_delay > 0) ? alc_force_delay : $urandom_range(1, 5);
            end
            seen = bus.txn_valid;
            if (pending) begin
               if (left <= 1) begin
                  pending = 0;
                  bus.desc_alc_valid = 1'b1;
                  bus.desc_alc_idx = (alc_idx_q.size() > 0) ? alc_idx_q.pop_front()
                                                           : DW'($urandom_range(0, 7));
                  exp_q.push_back(bus.desc_alc_idx);
                  last_alc_cyc = cyc;
               end else begin
                  left--;
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic model_reset();
      for (int i = 0; i < NREQ; i++) m_cnt[i] = 0;
      m_ptr   = NREQ - 1;
      m_under = 0;
      exp_q.delete();
      alc_idx_q.delete();
      alc_force_delay = 0;
   endtask

   task automatic apply_reset(input int cycles);
      @(negedge clk);
      resetn  = 1'b0;
      bus.req = '0;
      bus.rel = '0;
      repeat (cycles) @(negedge clk);
      model_reset();
      resetn = 1'b1;
   endtask

   // Observes the next grant pulse; no checking here.
   task automatic wait_gnt(output logic [NREQ-1:0] g, output logic [DW-1:0] idx,
                           output int lat, output bit to);
      g = '0;
      idx = '0;
      lat = -1;
      to = 1;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (bus.gnt !== '0) begin
            g = bus.gnt;
            idx = bus.gnt_desc_idx;
            lat = cyc - last_alc_cyc;
            to = 0;
            break;
         end
      end
   endtask

   function automatic logic [DW-1:0] pop_exp();
      return (exp_q.size() > 0) ? exp_q.pop_front() : '0;
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      resetn  = 1'b0;
      bus.req = '0;
      bus.rel = '0;
      model_reset();
      repeat (3) @(negedge clk);
      n_vec++; if (bus.gnt !== '0) begin n_err++; $display("FAIL reset_gnt: got %b want 000", bus.gnt); end
      n_vec++; if (bus.gnt_desc_idx !== '0) begin n_err++; $display("FAIL reset_idx: got %0d want 0", bus.gnt_desc_idx); end
      n_vec++; if (bus.txn_valid !== 1'b0) begin n_err++; $display("FAIL reset_txn: got %b want 0", bus.txn_valid); end
      n_vec++; if (bus.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
      n_vec++; if (bus.err_underflow !== 1'b0) begin n_err++; $display("FAIL reset_err: got %b want 0", bus.err_underflow); end
      n_vec++; if (bus.dbg_state !== ARB_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", bus.dbg_state, ARB_IDLE); end
      resetn = 1'b1;
   endtask

   task automatic test_single();
      logic [NREQ-1:0] g;
      logic [DW-1:0] idx;
      int lat, w;
      bit to;
      alc_idx_q.push_back(3'd5);
      bus.req = 3'b001;
      w = model_pick(3'b001);
      @(negedge clk);
      n_vec++;
      if (bus.txn_valid !== 1'b1 || bus.busy !== 1'b1) begin
         n_err++; $display("FAIL single_txn_rise: txn_valid=%b busy=%b want 1 1", bus.txn_valid, bus.busy);
      end
      wait_gnt(g, idx, lat, to);
      bus.req = '0;
      void'(pop_exp());
      n_vec++;
      if (to || g !== onehot(w) || idx !== 3'd5 || lat != 1) begin
         n_err++; $display("FAIL single_grant: gnt=%b idx=%0d lat=%0d to=%0b want gnt=%b idx=5 lat=1", g, idx, lat, to, onehot(w));
      end
      if (w >= 0) begin m_cnt[w]++; m_ptr = w; end
      @(negedge clk);
      n_vec++;
      if (bus.gnt !== '0 || bus.txn_valid !== 1'b0) begin
         n_err++; $display("FAIL single_gap: gnt=%b txn_valid=%b want 000 0", bus.gnt, bus.txn_valid);
      end
   endtask

   // Continues from test_single without reset; each winner releases right away.
   task automatic test_round_robin();
      logic [NREQ-1:0] g;
      logic [DW-1:0] idx, e_idx;
      int lat, w;
      bit to;
      for (int k = 0; k < 6; k++) alc_idx_q.push_back(DW'(k));
      bus.req = 3'b111;
      for (int k = 0; k < 6; k++) begin
         w = model_pick(3'b111);
         wait_gnt(g, idx, lat, to);
         bus.rel = onehot(w);
         if (k == 5) bus.req = '0;
         e_idx = pop_exp();
         n_vec++;
         if (to || g !== onehot(w) || idx !== e_idx || lat != 1) begin
            n_err++; $display("FAIL rr_grant%0d: gnt=%b idx=%0d lat=%0d to=%0b want gnt=%b idx=%0d lat=1", k, g, idx, lat, to, onehot(w), e_idx);
         end
         if (w >= 0) m_ptr = w;
         @(negedge clk);
         bus.rel = '0;
         n_vec++;
         if (bus.gnt !== '0 || bus.txn_valid !== 1'b0) begin
            n_err++; $display("FAIL rr_gap%0d: gnt=%b txn_valid=%b want 000 0", k, bus.gnt, bus.txn_valid);
         end
      end
   endtask

   task automatic test_quota();
      logic [NREQ-1:0] g;
      logic [DW-1:0] idx, e_idx;
      int lat, w, hi;
      bit to;
      apply_reset(2);
      bus.req = 3'b001;
      for (int k = 0; k < 3; k++) begin
         if (k == 2) begin
            hi = 0;
            repeat (15) begin
               @(negedge clk);
               if (bus.txn_valid !== 1'b0 || bus.gnt !== '0) hi++;
            end
            n_vec++;
            if (hi != 0) begin n_err++; $display("FAIL quota_block: %0d active cycles want 0", hi); end
            bus.rel = 3'b001;
            m_cnt[0]--;
            @(negedge clk);
            bus.rel = '0;
            n_vec++;
            if (bus.txn_valid !== 1'b0) begin n_err++; $display("FAIL quota_rel_same: txn_valid=%b want 0", bus.txn_valid); end
            @(negedge clk);
            n_vec++;
            if (bus.txn_valid !== 1'b1) begin n_err++; $display("FAIL quota_rel_next: txn_valid=%b want 1", bus.txn_valid); end
         end
         w = model_pick(3'b001);
         wait_gnt(g, idx, lat, to);
         if (k == 2) bus.req = '0;
         e_idx = pop_exp();
         n_vec++;
         if (to || g !== onehot(w) || idx !== e_idx || lat != 1) begin
            n_err++; $display("FAIL quota_grant%0d: gnt=%b idx=%0d lat=%0d to=%0b want gnt=%b idx=%0d", k, g, idx, lat, to, onehot(w), e_idx);
         end
         if (w >= 0) begin m_cnt[w]++; m_ptr = w; end
         @(negedge clk);
      end
   endtask

   task automatic test_alloc_stall();
      logic [NREQ-1:0] g;
      logic [DW-1:0] idx, e_idx;
      int lat, w, bad;
      bit to, rose;
      apply_reset(2);
      alc_force_delay = 50;
      bus.req = 3'b010;
      w = model_pick(3'b010);
      rose = 0;
      for (int i = 0; i < 10 && !rose; i++) begin
         @(negedge clk);
         rose = (bus.txn_valid === 1'b1);
      end
      n_vec++;
      if (!rose) begin n_err++; $display("FAIL stall_txn_rise: txn_valid=%b want 1", bus.txn_valid); end
      bad = 0;
      repeat (45) begin
         @(negedge clk);
         if (bus.txn_valid !== 1'b1 || bus.busy !== 1'b1 || bus.gnt !== '0 || bus.dbg_state !== ARB_WAIT) bad++;
      end
      n_vec++;
      if (bad != 0) begin n_err++; $display("FAIL stall_hold: %0d bad cycles want 0", bad); end
      wait_gnt(g, idx, lat, to);
      bus.req = '0;
      alc_force_delay = 0;
      e_idx = pop_exp();
      n_vec++;
      if (to || g !== onehot(w) || idx !== e_idx || lat != 1) begin
         n_err++; $display("FAIL stall_grant: gnt=%b idx=%0d lat=%0d to=%0b want gnt=%b idx=%0d lat=1", g, idx, lat, to, onehot(w), e_idx);
      end
      if (w >= 0) begin m_cnt[w]++; m_ptr = w; end
      @(negedge clk);
   endtask

   task automatic test_same_cycle_rel();
      logic [NREQ-1:0] g;
      logic [DW-1:0] idx, e_idx;
      int lat, w, hi;
      bit to, hit;
      apply_reset(2);
      for (int k = 0; k < 3; k++) begin
         bus.req = 3'b010;
         w = model_pick(3'b010);
         if (k == 1) begin
            hit = 0;
            for (int i = 0; i < 300 && !hit; i++) begin
               @(negedge clk);
               #1;
               if (bus.desc_alc_valid === 1'b1) begin bus.rel = 3'b010; hit = 1; end
            end
         end
         wait_gnt(g, idx, lat, to);
         bus.rel = '0;
         if (k < 2) bus.req = '0;
         e_idx = pop_exp();
         n_vec++;
         if (to || g !== onehot(w) || idx !== e_idx || lat != 1) begin
            n_err++; $display("FAIL samecyc_grant%0d: gnt=%b idx=%0d lat=%0d to=%0b want gnt=%b idx=%0d", k, g, idx, lat, to, onehot(w), e_idx);
         end
         if (w >= 0) begin
            if (k != 1) m_cnt[w]++;
            m_ptr = w;
         end
         @(negedge clk);
      end
      hi = 0;
      repeat (15) begin
         @(negedge clk);
         if (bus.txn_valid !== 1'b0) hi++;
      end
      bus.req = '0;
      n_vec++;
      if (hi != 0) begin n_err++; $display("FAIL samecyc_quota: %0d txn cycles want 0", hi); end
      n_vec++;
      if (bus.err_underflow !== m_under) begin n_err++; $display("FAIL underflow_pre: got %b want %b", bus.err_underflow, m_under); end
      bus.rel = 3'b100;
      if (m_cnt[2] == 0) m_under = 1; else m_cnt[2]--;
      @(negedge clk);
      bus.rel = '0;
      n_vec++;
      if (bus.err_underflow !== m_under) begin n_err++; $display("FAIL underflow_set: got %b want %b", bus.err_underflow, m_under); end
      repeat (6) @(negedge clk);
      n_vec++;
      if (bus.err_underflow !== m_under) begin n_err++; $display("FAIL underflow_sticky: got %b want %b", bus.err_underflow, m_under); end
   endtask

   task automatic test_reset_in_wait();
      logic [NREQ-1:0] g;
      logic [DW-1:0] idx, e_idx;
      int lat, w, bad;
      bit to, rose;
      apply_reset(2);
      alc_force_delay = 20;
      bus.req = 3'b001;
      rose = 0;
      for (int i = 0; i < 10 && !rose; i++) begin
         @(negedge clk);
         rose = (bus.txn_valid === 1'b1);
      end
      n_vec++;
      if (!rose) begin n_err++; $display("FAIL rstwait_rise: txn_valid=%b want 1", bus.txn_valid); end
      repeat (3) @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      n_vec++;
      if (bus.txn_valid !== 1'b0 || bus.busy !== 1'b0 || bus.gnt !== '0) begin
         n_err++; $display("FAIL rstwait_abort: txn=%b busy=%b gnt=%b want 0 0 000", bus.txn_valid, bus.busy, bus.gnt);
      end
      bad = 0;
      repeat (2) begin
         @(negedge clk);
         if (bus.gnt !== '0 || bus.txn_valid !== 1'b0) bad++;
      end
      model_reset();
      resetn = 1'b1;
      n_vec++;
      if (bad != 0) begin n_err++; $display("FAIL rstwait_quiet: %0d active cycles want 0", bad); end
      w = model_pick(3'b001);
      wait_gnt(g, idx, lat, to);
      bus.req = '0;
      e_idx = pop_exp();
      n_vec++;
      if (to || g !== onehot(w) || idx !== e_idx || lat != 1) begin
         n_err++; $display("FAIL rstwait_grant: gnt=%b idx=%0d lat=%0d to=%0b want gnt=%b idx=%0d", g, idx, lat, to, onehot(w), e_idx);
      end
      @(negedge clk);
   endtask

   task automatic test_random();
      logic [NREQ-1:0] r, rv, g, elig_m;
      logic [DW-1:0] idx, e_idx;
      int lat, w;
      bit to;
      apply_reset(2);
      r = NREQ'($urandom_range(1, 7));
      bus.req = r;
      for (int k = 0; k < 24; k++) begin
         w = model_pick(r);
         wait_gnt(g, idx, lat, to);
         if (w >= 0) begin m_cnt[w]++; m_ptr = w; end
         rv = NREQ'($urandom_range(0, 7));
         elig_m = '0;
         for (int i = 0; i < NREQ; i++) begin
            if (m_cnt[i] == 0) rv[i] = 1'b0;
            if (rv[i]) m_cnt[i]--;
            if (m_cnt[i] < QUOTA) elig_m[i] = 1'b1;
         end
         if (elig_m == '0 && w >= 0) begin
            rv[w] = 1'b1;
            m_cnt[w]--;
            elig_m[w] = 1'b1;
         end
         r = NREQ'($urandom_range(1, 7));
         if ((r & elig_m) == '0) r = elig_m;
         bus.rel = rv;
         bus.req = (k == 23) ? '0 : r;
         e_idx = pop_exp();
         n_vec++;
         if (to || g !== onehot(w) || idx !== e_idx || lat != 1) begin
            n_err++; $display("FAIL rand_grant%0d: gnt=%b idx=%0d lat=%0d to=%0b want gnt=%b idx=%0d lat=1", k, g, idx, lat, to, onehot(w), e_idx);
         end
         @(negedge clk);
         bus.rel = '0;
         n_vec++;
         if (bus.gnt !== '0 || bus.txn_valid !== 1'b0) begin
            n_err++; $display("FAIL rand_gap%0d: gnt=%b txn_valid=%b want 000 0", k, bus.gnt, bus.txn_valid);
         end
      end
      n_vec++;
      if (bus.err_underflow !== 1'b0) begin n_err++; $display("FAIL rand_no_underflow: got %b want 0", bus.err_underflow); end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      bus.req = '0;
      bus.rel = '0;
      test_reset();
      test_single();
      test_round_robin();
      test_quota();
      test_alloc_stall();
      test_same_cycle_rel();
      test_reset_in_wait();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
